// File: rtl/core_rvfi_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : core_rvfi_tracker                                          |
// | Description : In-order RVFI retirement queue. Accepts up to NRET         |
// |               retirement records per cycle, holds records that wait on a |
// |               data-memory response, merges the response in, and emits    |
// |               records in program order with a 64-bit order stamp.        |
// | Options     : RVFI_TRACKER_OVF_EN adds a sticky 'overflow' output.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Record layout, MSB to LSB: insn, one spare XLEN-wide slot (passed through),
// pc_rdata, pc_wdata, rs1_addr, rs2_addr, rs1_rdata, rs2_rdata, rd_addr,
// rd_wdata, mem_addr, mem_rmask, mem_wmask, mem_wdata, trap, intr.
// Fields are anchored from the LSB, so rd_wdata and trap sit at fixed offsets.
module core_rvfi_tracker #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int NRET  = 2,
   parameter int DEPTH = 8,
   localparam int RECW = ILEN + 8*XLEN + 15 + XLEN/4 + 2
) (
   input  logic                 g_clk,
   input  logic                 g_resetn,
   input  logic [NRET-1:0]      in_valid,
   input  logic [NRET-1:0]      in_mem,
   input  logic [NRET*RECW-1:0] in_rec,
   output logic                 in_ready,
`ifdef RVFI_TRACKER_OVF_EN
   output logic                 overflow,
`endif
   input  logic                 rsp_valid,
   input  logic [XLEN-1:0]      rsp_rdata,
   input  logic [XLEN-1:0]      rsp_rd_wdata,
   input  logic                 rsp_error,
   output logic [NRET-1:0]      rvfi_valid,
   output logic [NRET*64-1:0]   rvfi_order,
   output logic [NRET*RECW-1:0] rvfi_rec,
   output logic [NRET*XLEN-1:0] rvfi_mem_rdata,
   output logic [NRET*2-1:0]    rvfi_mode,
   output logic [NRET*2-1:0]    rvfi_ixl,
   output logic [NRET-1:0]      rvfi_halt
);

   localparam int              AW        = $clog2(DEPTH);
   localparam int              PW        = AW + 1;
   localparam int              RD_LSB    = 2 + 2*XLEN + XLEN/4;
   localparam int              TRAP_BIT  = 1;
   localparam logic [1:0]      IXL       = (XLEN == 64) ? 2'd2 : 2'd1;
   localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
   localparam logic [PW-1:0]   READY_MAX = PW'(DEPTH - NRET);

   // Queue storage and bookkeeping
   logic [RECW-1:0] r_rec   [DEPTH];
   logic [XLEN-1:0] r_rdata [DEPTH];
   logic [DEPTH-1:0] r_done;
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [PW-1:0]   r_rsp;
   logic [63:0]     r_order;
   logic            r_in_ready;

   logic [NRET-1:0] w_lane_push;
   logic [PW-1:0]   w_lane_slot [NRET];
   logic [PW-1:0]   w_push_n;
   logic [PW-1:0]   w_pop_slot  [NRET];
   logic [PW-1:0]   w_pop_n;
   logic            w_pop_stop;
   logic [PW-1:0]   w_occ;
   logic [PW-1:0]   w_head_nxt;
   logic [PW-1:0]   w_tail_nxt;
   logic [PW-1:0]   w_occ_nxt;
   logic [PW-1:0]   w_rsp_span;
   logic [PW-1:0]   w_rsp_nxt;
   logic [PW-1:0]   w_scan_slot;
   logic            w_rsp_found;
   logic            w_rsp_hit;
   logic [DEPTH-1:0] w_done_nxt;

   assign w_occ      = r_tail - r_head;
   assign w_head_nxt = r_head + w_pop_n;
   assign w_tail_nxt = r_tail + w_push_n;
   assign w_occ_nxt  = w_tail_nxt - w_head_nxt;
   assign w_rsp_span = w_tail_nxt - r_rsp;
   // r_rsp == r_tail means nothing is waiting on memory
   assign w_rsp_hit  = rsp_valid && (r_rsp != r_tail);
   assign in_ready   = r_in_ready;

   // Slot assignment for accepted lanes, packed in lane order from the tail
   always_comb begin
      w_push_n    = '0;
      w_lane_push = '0;
      for (int j = 0; j < NRET; j++) begin
         w_lane_push[j] = r_in_ready & in_valid[j];
         w_lane_slot[j] = r_tail + w_push_n;
         if (w_lane_push[j]) w_push_n = w_push_n + PTR_ONE;
      end
   end

   // Pop count: contiguous complete entries from the head, capped at NRET
   always_comb begin
      w_pop_n    = '0;
      w_pop_stop = 1'b0;
      for (int j = 0; j < NRET; j++) begin
         w_pop_slot[j] = r_head + PW'(j);
         if (!w_pop_stop && (PW'(j) < w_occ) && r_done[w_pop_slot[j][AW-1:0]])
            w_pop_n = w_pop_n + PTR_ONE;
         else
            w_pop_stop = 1'b1;
      end
   end

   // Next complete flags and the next oldest-incomplete pointer
   always_comb begin
      w_done_nxt = r_done;
      for (int j = 0; j < NRET; j++) begin
         if (w_lane_push[j]) w_done_nxt[w_lane_slot[j][AW-1:0]] = ~in_mem[j];
      end
      if (w_rsp_hit) w_done_nxt[r_rsp[AW-1:0]] = 1'b1;
      w_rsp_nxt   = w_tail_nxt;
      w_rsp_found = 1'b0;
      w_scan_slot = r_rsp;
      for (int i = 0; i < DEPTH; i++) begin
         w_scan_slot = r_rsp + PW'(i);
         if (!w_rsp_found && (PW'(i) < w_rsp_span) && !w_done_nxt[w_scan_slot[AW-1:0]]) begin
            w_rsp_nxt   = w_scan_slot;
            w_rsp_found = 1'b1;
         end
      end
   end

   // Pointer, flag and order-counter state
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_rsp      <= '0;
         r_done     <= '0;
         r_order    <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_head     <= w_head_nxt;
         r_tail     <= w_tail_nxt;
         r_rsp      <= w_rsp_nxt;
         r_done     <= w_done_nxt;
         r_order    <= r_order + 64'(w_pop_n);
         r_in_ready <= (w_occ_nxt <= READY_MAX);
      end
   end

   // Record payload writes: push into free slots, merge responses in place
   always_ff @(posedge g_clk) begin
      for (int j = 0; j < NRET; j++) begin
         if (w_lane_push[j]) begin
            r_rec[w_lane_slot[j][AW-1:0]]   <= in_rec[j*RECW +: RECW];
            r_rdata[w_lane_slot[j][AW-1:0]] <= '0;
         end
      end
      if (w_rsp_hit) begin
         r_rec[r_rsp[AW-1:0]][RD_LSB +: XLEN] <= rsp_rd_wdata;
         r_rec[r_rsp[AW-1:0]][TRAP_BIT]       <= r_rec[r_rsp[AW-1:0]][TRAP_BIT] | rsp_error;
         r_rdata[r_rsp[AW-1:0]]               <= rsp_rdata;
      end
   end

   // Output registers; idle lanes keep their previous payload
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         rvfi_valid     <= '0;
         rvfi_order     <= '0;
         rvfi_rec       <= '0;
         rvfi_mem_rdata <= '0;
      end else begin
         for (int j = 0; j < NRET; j++) begin
            rvfi_valid[j] <= (PW'(j) < w_pop_n);
            if (PW'(j) < w_pop_n) begin
               rvfi_order[j*64 +: 64]         <= r_order + 64'(j);
               rvfi_rec[j*RECW +: RECW]       <= r_rec[w_pop_slot[j][AW-1:0]];
               rvfi_mem_rdata[j*XLEN +: XLEN] <= r_rdata[w_pop_slot[j][AW-1:0]];
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NRET; g++) begin : g_const
         assign rvfi_mode[g*2 +: 2] = 2'b11;
         assign rvfi_ixl[g*2 +: 2]  = IXL;
         assign rvfi_halt[g]        = 1'b0;
      end
   endgenerate

`ifdef RVFI_TRACKER_OVF_EN
   // Sticky flag for dropped pushes and orphan responses
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn)
         overflow <= 1'b0;
      else if (((|in_valid) && !r_in_ready) || (rsp_valid && !w_rsp_hit))
         overflow <= 1'b1;
   end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_rvfi_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_core_rvfi_tracker                                       |
// | Description : Self-checking bench for core_rvfi_tracker against a        |
// |               queue-based reference model, directed and random stimulus. |
// |               RVFI_TRACKER_OVF_EN also checks the overflow flag.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_core_rvfi_tracker;

   localparam int XLEN   = 64;
   localparam int ILEN   = 32;
   localparam int NRET   = 2;
   localparam int DEPTH  = 8;
   localparam int RECW   = ILEN + 8*XLEN + 15 + XLEN/4 + 2;
   localparam int RD_LSB = 2 + 2*XLEN + XLEN/4;

   logic                 g_clk = 1'b0;
   logic                 g_resetn = 1'b0;
   logic [NRET-1:0]      in_valid = '0;
   logic [NRET-1:0]      in_mem = '0;
   logic [NRET*RECW-1:0] in_rec = '0;
   logic                 in_ready;
   logic                 rsp_valid = 1'b0;
   logic [XLEN-1:0]      rsp_rdata = '0;
   logic [XLEN-1:0]      rsp_rd_wdata = '0;
   logic                 rsp_error = 1'b0;
   logic [NRET-1:0]      rvfi_valid;
   logic [NRET*64-1:0]   rvfi_order;
   logic [NRET*RECW-1:0] rvfi_rec;
   logic [NRET*XLEN-1:0] rvfi_mem_rdata;
   logic [NRET*2-1:0]    rvfi_mode;
   logic [NRET*2-1:0]    rvfi_ixl;
   logic [NRET-1:0]      rvfi_halt;
`ifdef RVFI_TRACKER_OVF_EN
   logic                 overflow;
`endif

   core_rvfi_tracker #(.XLEN(XLEN), .ILEN(ILEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .in_valid(in_valid), .in_mem(in_mem), .in_rec(in_rec), .in_ready(in_ready),
`ifdef RVFI_TRACKER_OVF_EN
      .overflow(overflow),
`endif
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd_wdata(rsp_rd_wdata),
      .rsp_error(rsp_error), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
      .rvfi_rec(rvfi_rec), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mode(rvfi_mode),
      .rvfi_ixl(rvfi_ixl), .rvfi_halt(rvfi_halt)
   );

   always #5 g_clk = ~g_clk;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [RECW-1:0] got, input logic [RECW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: a plain queue of records in program order
   typedef struct {
      logic [RECW-1:0] rec;
      logic [XLEN-1:0] rdata;
      bit              done;
   } ent_t;

   ent_t            q[$];
   logic [63:0]     m_order;
   bit              m_ready;
   bit              m_ovf;
   logic [NRET-1:0] e_valid;
   logic [63:0]     e_order [NRET];
   logic [RECW-1:0] e_rec   [NRET];
   logic [XLEN-1:0] e_rdata [NRET];
   logic [63:0]     seen;
   bit              clr_trap = 1'b1;

   task automatic model_reset();
      q.delete();
      m_order = '0;
      m_ready = 1'b0;
      m_ovf   = 1'b0;
      e_valid = '0;
      seen    = '0;
      for (int j = 0; j < NRET; j++) begin
         e_order[j] = '0;
         e_rec[j]   = '0;
         e_rdata[j] = '0;
      end
   endtask

   task automatic model_step();
      int   k;
      bit   hit;
      ent_t e;
      if (!g_resetn) begin
         model_reset();
         return;
      end
      k = 0;
      while (k < NRET && k < q.size() && q[k].done) k++;
      hit = 1'b0;
      if (rsp_valid) begin
         for (int i = 0; i < q.size(); i++) begin
            if (!hit && !q[i].done) begin
               e = q[i];
               e.rec[RD_LSB +: XLEN] = rsp_rd_wdata;
               e.rec[1] = e.rec[1] | rsp_error;
               e.rdata  = rsp_rdata;
               e.done   = 1'b1;
               q[i]     = e;
               hit      = 1'b1;
            end
         end
      end
      if (((|in_valid) && !m_ready) || (rsp_valid && !hit)) m_ovf = 1'b1;
      e_valid = '0;
      for (int j = 0; j < k; j++) begin
         e_valid[j] = 1'b1;
         e_order[j] = m_order + 64'(j);
         e_rec[j]   = q[0].rec;
         e_rdata[j] = q[0].rdata;
         void'(q.pop_front());
      end
      m_order = m_order + 64'(k);
      if (m_ready) begin
         for (int j = 0; j < NRET; j++) begin
            if (in_valid[j]) begin
               e.rec   = in_rec[j*RECW +: RECW];
               e.rdata = '0;
               e.done  = !in_mem[j];
               q.push_back(e);
            end
         end
      end
      m_ready = (DEPTH - q.size()) >= NRET;
   endtask

   task automatic compare();
      check_val("valid", RECW'(rvfi_valid), RECW'(e_valid));
      check_val("in_ready", RECW'(in_ready), RECW'(m_ready));
`ifdef RVFI_TRACKER_OVF_EN
      check_val("overflow", RECW'(overflow), RECW'(m_ovf));
`endif
      for (int j = 0; j < NRET; j++) begin
         check_val($sformatf("order%0d", j), RECW'(rvfi_order[j*64 +: 64]), RECW'(e_order[j]));
         check_val($sformatf("rec%0d", j), rvfi_rec[j*RECW +: RECW], e_rec[j]);
         check_val($sformatf("rdata%0d", j), RECW'(rvfi_mem_rdata[j*XLEN +: XLEN]), RECW'(e_rdata[j]));
      end
      // Independent continuity check of the stamps seen so far
      for (int j = 0; j < NRET; j++) begin
         if (rvfi_valid[j]) begin
            check_val("order_seq", RECW'(rvfi_order[j*64 +: 64]), RECW'(seen));
            seen = seen + 64'd1;
         end
      end
   endtask

   function automatic logic [RECW-1:0] rand_rec();
      logic [RECW-1:0] r;
      r = '0;
      for (int b = 0; b < (RECW + 31) / 32; b++) r = {r[RECW-33:0], 32'($urandom())};
      if (clr_trap) r[1] = 1'b0;
      return r;
   endfunction

   task automatic drive(input int n, input logic [NRET-1:0] mem, input bit rv,
                        input logic [XLEN-1:0] rd, input bit err);
      in_valid = '0;
      in_mem   = mem;
      for (int j = 0; j < NRET; j++) begin
         in_rec[j*RECW +: RECW] = rand_rec();
         if (j < n) in_valid[j] = 1'b1;
      end
      rsp_valid    = rv;
      rsp_rdata    = rd;
      rsp_rd_wdata = {32'($urandom()), 32'($urandom())};
      rsp_error    = err;
   endtask

   task automatic cycle();
      @(posedge g_clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic step(input int n, input logic [NRET-1:0] mem, input bit rv,
                       input logic [XLEN-1:0] rd, input bit err);
      drive(n, mem, rv, rd, err);
      cycle();
   endtask

   task automatic idle(input int c);
      repeat (c) step(0, '0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      model_reset();
      drive(0, '0, 1'b0, '0, 1'b0);
      cycle();
      cycle();
      check_val("mode", RECW'(rvfi_mode), RECW'(4'b1111));
      check_val("ixl", RECW'(rvfi_ixl), RECW'(4'b1010));
      check_val("halt", RECW'(rvfi_halt), RECW'(2'b00));
      g_resetn = 1'b1;
      cycle();
      check_val("ready_after_rst", RECW'(in_ready), RECW'(1'b1));

      // Two ALU records, then a lone one
      step(2, 2'b00, 1'b0, '0, 1'b0);
      step(1, 2'b00, 1'b0, '0, 1'b0);
      check_val("t1_valid", RECW'(rvfi_valid), RECW'(2'b11));
      check_val("t1_order1", RECW'(rvfi_order[127:64]), RECW'(64'd1));
      idle(1);
      check_val("t1_lone_valid", RECW'(rvfi_valid), RECW'(2'b01));
      check_val("t1_lone_order", RECW'(rvfi_order[63:0]), RECW'(64'd2));
      idle(2);

      // Load blocks three younger ALU records
      step(1, 2'b01, 1'b0, '0, 1'b0);
      step(2, 2'b00, 1'b0, '0, 1'b0);
      step(1, 2'b00, 1'b0, '0, 1'b0);
      idle(2);
      check_val("ld_held", RECW'(rvfi_valid), RECW'(2'b00));
      step(0, '0, 1'b1, 64'hDEAD_BEEF, 1'b0);
      idle(1);
      check_val("ld_valid", RECW'(rvfi_valid), RECW'(2'b11));
      check_val("ld_rdata", RECW'(rvfi_mem_rdata[XLEN-1:0]), RECW'(64'hDEAD_BEEF));
      idle(3);

      // Two loads, bus error on the first
      step(2, 2'b11, 1'b0, '0, 1'b0);
      idle(1);
      step(0, '0, 1'b1, 64'h1111, 1'b1);
      idle(1);
      check_val("err_valid", RECW'(rvfi_valid), RECW'(2'b01));
      check_val("err_trap", RECW'(rvfi_rec[1]), RECW'(1'b1));
      idle(2);
      step(0, '0, 1'b1, 64'h2222, 1'b0);
      idle(1);
      check_val("ok_trap", RECW'(rvfi_rec[1]), RECW'(1'b0));
      idle(2);

      // Fill with incomplete records, push while not ready, then drain
      repeat (3) step(2, 2'b11, 1'b0, '0, 1'b0);
      step(1, 2'b01, 1'b0, '0, 1'b0);
      check_val("full_ready", RECW'(in_ready), RECW'(1'b0));
      step(2, 2'b00, 1'b0, '0, 1'b0);
      for (int i = 0; i < 7; i++) step(0, '0, 1'b1, 64'(i + 100), 1'b0);
      idle(5);
      check_val("drained_ready", RECW'(in_ready), RECW'(1'b1));

      // Sustained push/pop around occupancy 6 across pointer wrap
      step(2, 2'b01, 1'b0, '0, 1'b0);
      step(2, 2'b00, 1'b0, '0, 1'b0);
      step(2, 2'b00, 1'b0, '0, 1'b0);
      for (int i = 0; i < 20; i++) step(m_ready ? 2 : 0, 2'b00, (i == 0), 64'h55, 1'b0);
      idle(6);

      // Random traffic, including occasional protocol violations and orphans
      clr_trap = 1'b0;
      for (int i = 0; i < 300; i++) begin
         int n;
         n = $urandom_range(0, NRET);
         if (!m_ready && ($urandom_range(0, 9) != 0)) n = 0;
         step(n, NRET'($urandom()), ($urandom_range(0, 9) < 3),
              {32'($urandom()), 32'($urandom())}, ($urandom_range(0, 3) == 0));
      end
      clr_trap = 1'b1;
      for (int i = 0; i < DEPTH; i++) step(0, '0, 1'b1, 64'h77, 1'b0);
      idle(4);

      // Reset mid-drain with two loads pending
      step(2, 2'b00, 1'b0, '0, 1'b0);
      step(2, 2'b11, 1'b0, '0, 1'b0);
      check_val("pre_rst_valid", RECW'(rvfi_valid), RECW'(2'b11));
      g_resetn = 1'b0;
      #1;
      check_val("rst_valid", RECW'(rvfi_valid), RECW'(2'b00));
      check_val("rst_ready", RECW'(in_ready), RECW'(1'b0));
      model_reset();
      cycle();
      g_resetn = 1'b1;
      step(0, '0, 1'b1, 64'h99, 1'b0);
      step(0, '0, 1'b1, 64'h98, 1'b0);
      step(1, 2'b00, 1'b0, '0, 1'b0);
      idle(1);
      check_val("post_rst_order", RECW'(rvfi_order[63:0]), RECW'(64'd0));
      check_val("post_rst_valid", RECW'(rvfi_valid), RECW'(2'b01));
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
